// File: rtl/rdb_pkg.sv
// Shared definitions for the read/D ping-pong buffer: symbol codes,
// loader states and the "-1" address helper.
package rdb_pkg;

  localparam int unsigned SYM_CODE_W = 2;

  localparam logic [SYM_CODE_W-1:0] SYM_A = 2'b00;
  localparam logic [SYM_CODE_W-1:0] SYM_C = 2'b01;
  localparam logic [SYM_CODE_W-1:0] SYM_G = 2'b10;
  localparam logic [SYM_CODE_W-1:0] SYM_T = 2'b11;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_FILL = 2'd1,
    L_FULL = 2'd2
  } load_state_t;

  // All-ones value of a w-bit address, used as the "-1" position.
  function automatic logic [31:0] neg_one(input int unsigned w);
    if (w >= 32) begin
      return '1;
    end
    return (32'(1) << w) - 32'(1);
  endfunction

endpackage

// File: rtl/rdb_bank.sv
// One bank: 1-write/1-read synchronous memory with a registered read port.
// The read register can be forced to zero on a per-request basis.
module rdb_bank #(
  parameter int unsigned W      = 10,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  input  logic              rd_zero,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [W-1:0] mem [DEPTH];

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: rtl/read_d_pingpong_buffer.sv
// Double-buffered symbol/D(i) store: loader fills the inactive bank, engine reads the active one.
// Optional macro RDB_RANGE_CHECK_EN zeroes and flags reads at or beyond rd_len.
module read_d_pingpong_buffer
  import rdb_pkg::*;
#(
  parameter int unsigned SYM_W  = 2,
  parameter int unsigned D_W    = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [SYM_W-1:0]  wr_sym,
  input  logic [D_W-1:0]    wr_d,
  input  logic              wr_last,
  output logic              load_done,
  input  logic              swap,
  output logic              active_valid,
  output logic [ADDR_W-1:0] rd_len,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [SYM_W-1:0]  rd_sym,
  output logic [D_W-1:0]    rd_d,
  output logic              rd_oob
);

  localparam int unsigned ENT_W = SYM_W + D_W;
  localparam logic [ADDR_W-1:0] NEG_ONE  = ADDR_W'(neg_one(ADDR_W));
  localparam logic [ADDR_W-1:0] LAST_PTR = NEG_ONE - ADDR_W'(1);

  load_state_t       state, state_next;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_next;
  logic [ADDR_W-1:0] pend_len, pend_len_next;
  logic [ADDR_W-1:0] rd_len_next;
  logic              active_bank, active_bank_next;
  logic              active_valid_next;
  logic              load_done_next;
  logic              wr_ready_next;
  logic              bank_we;
  logic              wr_fire;

  logic              addr_neg;
  logic              oob_hit;
  logic              rd_zero;
  logic              rd_sel;
  logic [ENT_W-1:0]  wr_data;
  logic [ENT_W-1:0]  q0, q1, q_sel;

  assign wr_fire = wr_valid && wr_ready;
  assign wr_data = {wr_sym, wr_d};

  // Loader next-state, pointer and bank-select logic.
  always_comb begin
    state_next        = state;
    wr_ptr_next       = wr_ptr;
    pend_len_next     = pend_len;
    rd_len_next       = rd_len;
    active_bank_next  = active_bank;
    active_valid_next = active_valid;
    load_done_next    = 1'b0;
    bank_we           = 1'b0;
    unique case (state)
      L_IDLE: begin
        if (load_start) begin
          state_next  = L_FILL;
          wr_ptr_next = '0;
        end
      end
      L_FILL: begin
        if (wr_fire) begin
          bank_we     = 1'b1;
          wr_ptr_next = wr_ptr + ADDR_W'(1);
          // Last legal slot truncates the read even without wr_last.
          if (wr_last || (wr_ptr == LAST_PTR)) begin
            pend_len_next  = wr_ptr + ADDR_W'(1);
            load_done_next = 1'b1;
            state_next     = L_FULL;
          end
        end
      end
      L_FULL: begin
        if (swap) begin
          active_bank_next  = ~active_bank;
          rd_len_next       = pend_len;
          active_valid_next = 1'b1;
          state_next        = L_IDLE;
        end
      end
      default: state_next = L_IDLE;
    endcase
    wr_ready_next = (state_next == L_FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= L_IDLE;
      wr_ptr       <= '0;
      pend_len     <= '0;
      rd_len       <= '0;
      active_bank  <= 1'b0;
      active_valid <= 1'b0;
      load_done    <= 1'b0;
      wr_ready     <= 1'b0;
    end else begin
      state        <= state_next;
      wr_ptr       <= wr_ptr_next;
      pend_len     <= pend_len_next;
      rd_len       <= rd_len_next;
      active_bank  <= active_bank_next;
      active_valid <= active_valid_next;
      load_done    <= load_done_next;
      wr_ready     <= wr_ready_next;
    end
  end

  assign addr_neg = (rd_addr == NEG_ONE);

`ifdef RDB_RANGE_CHECK_EN
  assign oob_hit = !addr_neg && (rd_addr >= rd_len);
`else
  assign oob_hit = 1'b0;
`endif

  assign rd_zero = addr_neg || !active_valid || oob_hit;

  // Response control; bank data registers live inside the banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_sel   <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_sel <= active_bank;
      end
    end
  end

`ifdef RDB_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_oob <= 1'b0;
    end else begin
      rd_oob <= rd_req && oob_hit;
    end
  end
`else
  assign rd_oob = 1'b0;
`endif

  rdb_bank #(
    .W      (ENT_W),
    .ADDR_W (ADDR_W)
  ) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_we && active_bank),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_req && !active_bank),
    .rd_zero (rd_zero),
    .rd_addr (rd_addr),
    .rd_data (q0)
  );

  rdb_bank #(
    .W      (ENT_W),
    .ADDR_W (ADDR_W)
  ) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bank_we && !active_bank),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_req && active_bank),
    .rd_zero (rd_zero),
    .rd_addr (rd_addr),
    .rd_data (q1)
  );

  assign q_sel  = rd_sel ? q1 : q0;
  assign rd_sym = q_sel[ENT_W-1:D_W];
  assign rd_d   = q_sel[D_W-1:0];

endmodule
